// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM (1-cycle read latency) between NUM_PORTS
// requesters, each with a one-entry response slot and independent response backpressure.
module bram_port_arbiter #(
  parameter int NUM_PORTS       = 2,
  parameter int DATA_WIDTH      = 64,
  parameter int BRAM_ADDR_WIDTH = 16
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic [NUM_PORTS-1:0]                 i_req_valid,
  output logic [NUM_PORTS-1:0]                 o_req_ready,
  input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0]  i_req_we,
  input  logic [NUM_PORTS*BRAM_ADDR_WIDTH-1:0] i_req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]      i_req_wrdata,
  output logic [NUM_PORTS-1:0]                 o_rsp_valid,
  input  logic [NUM_PORTS-1:0]                 i_rsp_ready,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]      o_rsp_data,
  output logic                                 o_bram_en,
  output logic [DATA_WIDTH/8-1:0]              o_bram_we,
  output logic [BRAM_ADDR_WIDTH-1:0]           o_bram_addr,
  output logic [DATA_WIDTH-1:0]                o_bram_wrdata,
  input  logic [DATA_WIDTH-1:0]                i_bram_rddata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [IDX_W-1:0]                     r_last;
  logic [NUM_PORTS-1:0]                 r_pend_vld_p1;
  logic [NUM_PORTS-1:0]                 r_rsp_is_wr_p1;
  logic [NUM_PORTS-1:0]                 r_slot_vld_p2;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] r_slot_d_p2;

  logic [NUM_PORTS-1:0]                 w_eligible;
  logic [NUM_PORTS-1:0][IDX_W-1:0]      w_cand;
  logic                                 w_grant_vld;
  logic [IDX_W-1:0]                     w_grant_idx;

  // Stage p0: eligibility and round-robin grant, BRAM driven combinationally
  always_comb begin
    w_eligible = i_req_valid & ~r_pend_vld_p1 & (~r_slot_vld_p2 | i_rsp_ready)
               & {NUM_PORTS{~i_rst}};
  end

  // Search order starts one past the last winner and wraps around.
  always_comb begin
    w_cand = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      w_cand[k] = (int'(r_last) + k + 1 >= NUM_PORTS)
                ? IDX_W'(int'(r_last) + k + 1 - NUM_PORTS)
                : IDX_W'(int'(r_last) + k + 1);
    end
  end

  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (!w_grant_vld && w_eligible[w_cand[k]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand[k];
      end
    end
  end

  always_comb begin
    o_req_ready   = '0;
    o_bram_en     = w_grant_vld;
    o_bram_we     = '0;
    o_bram_addr   = '0;
    o_bram_wrdata = '0;
    if (w_grant_vld) begin
      o_req_ready[w_grant_idx] = 1'b1;
      o_bram_we     = i_req_we[w_grant_idx*STRB_W +: STRB_W];
      o_bram_addr   = i_req_addr[w_grant_idx*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH];
      o_bram_wrdata = i_req_wrdata[w_grant_idx*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Stage p1: access in flight at the BRAM; stage p2: result captured in the response slot
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last         <= IDX_W'(NUM_PORTS - 1);
      r_pend_vld_p1  <= '0;
      r_rsp_is_wr_p1 <= '0;
      r_slot_vld_p2  <= '0;
      r_slot_d_p2    <= '0;
    end else begin
      if (w_grant_vld) begin
        r_last <= w_grant_idx;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (w_grant_vld && (w_grant_idx == IDX_W'(i))) begin
          r_pend_vld_p1[i]  <= 1'b1;
          r_rsp_is_wr_p1[i] <= |i_req_we[i*STRB_W +: STRB_W];
        end else begin
          r_pend_vld_p1[i]  <= 1'b0;
        end
        // A landing result takes priority over the consumer draining the slot.
        if (r_pend_vld_p1[i]) begin
          r_slot_vld_p2[i] <= 1'b1;
          r_slot_d_p2[i]   <= r_rsp_is_wr_p1[i] ? '0 : i_bram_rddata;
        end else if (r_slot_vld_p2[i] && i_rsp_ready[i]) begin
          r_slot_vld_p2[i] <= 1'b0;
        end
      end
    end
  end

  assign o_rsp_valid = r_slot_vld_p2 & {NUM_PORTS{~i_rst}};
  assign o_rsp_data  = r_slot_d_p2;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: behavioural BRAM, queue-based reference model and directed
// plus randomized scenarios, three ports.
module tb_bram_port_arbiter;

  localparam int NP = 3;
  localparam int DW = 64;
  localparam int AW = 16;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic [NP-1:0]    req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NP*SW-1:0] req_we;
  logic [NP*AW-1:0] req_addr;
  logic [NP*DW-1:0] req_wrdata, rsp_data;
  logic             bram_en;
  logic [SW-1:0]    bram_we;
  logic [AW-1:0]    bram_addr;
  logic [DW-1:0]    bram_wrdata, bram_rddata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bram_port_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .BRAM_ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_addr(req_addr), .i_req_wrdata(req_wrdata),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_bram_en(bram_en), .o_bram_we(bram_we), .o_bram_addr(bram_addr),
    .o_bram_wrdata(bram_wrdata), .i_bram_rddata(bram_rddata)
  );

  // Behavioural single-port BRAM, read-first, one cycle read latency
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (bram_en) begin
      bram_rddata <= mem[bram_addr[7:0]];
      for (int b = 0; b < SW; b++)
        if (bram_we[b]) mem[bram_addr[7:0]][b*8 +: 8] <= bram_wrdata[b*8 +: 8];
    end
  end

  function automatic logic [DW-1:0] init_word(input int a);
    if (a == 16'h10) return 64'hDEAD;
    return 64'hC0DE_0000_0000_0000 | 64'(a);
  endfunction

  // Reference model: per-port queue of expected responses with the cycle they become visible
  logic [DW-1:0] shadow [256];
  int            q_due [NP][$];
  logic [DW-1:0] q_dat [NP][$];
  logic [NP-1:0] exp_ready, exp_rv;
  logic          exp_en;
  logic [SW-1:0] exp_we;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wd;
  logic [DW-1:0] exp_rd [NP];
  int            m_last, m_cyc;

  task automatic model_step();
    logic [NP-1:0] elig;
    logic [SW-1:0] we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    int g, c;
    exp_ready = '0; exp_en = 1'b0; exp_we = '0; exp_addr = '0; exp_wd = '0; exp_rv = '0;
    for (int p = 0; p < NP; p++) exp_rd[p] = '0;
    if (rst) begin
      for (int p = 0; p < NP; p++) begin q_due[p].delete(); q_dat[p].delete(); end
      m_last = NP - 1;
    end else begin
      for (int p = 0; p < NP; p++) begin
        exp_rv[p] = (q_due[p].size() != 0) && (q_due[p][0] <= m_cyc);
        if (exp_rv[p]) exp_rd[p] = q_dat[p][0];
        elig[p] = req_valid[p] && ((q_due[p].size() == 0) || (exp_rv[p] && rsp_ready[p]));
      end
      g = -1;
      for (int k = 1; k <= NP; k++) begin
        c = (m_last + k) % NP;
        if (g < 0 && elig[c]) g = c;
      end
      for (int p = 0; p < NP; p++)
        if (exp_rv[p] && rsp_ready[p]) begin
          void'(q_due[p].pop_front());
          void'(q_dat[p].pop_front());
        end
      if (g >= 0) begin
        we = req_we[g*SW +: SW]; a = req_addr[g*AW +: AW]; wd = req_wrdata[g*DW +: DW];
        exp_ready[g] = 1'b1; exp_en = 1'b1; exp_we = we; exp_addr = a; exp_wd = wd;
        q_due[g].push_back(m_cyc + 2);
        q_dat[g].push_back((we != 0) ? 64'h0 : shadow[a[7:0]]);
        for (int b = 0; b < SW; b++) if (we[b]) shadow[a[7:0]][b*8 +: 8] = wd[b*8 +: 8];
        m_last = g;
      end
    end
    m_cyc++;
  endtask

  initial begin
    m_last = NP - 1;
    m_cyc  = 0;
    forever begin
      @(negedge clk);
      model_step();
    end
  end

  task automatic to_check(); @(negedge clk); #1; endtask
  task automatic to_drive(); @(posedge clk); #1; endtask

  task automatic set_req(input int p, input logic v, input logic [SW-1:0] we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[p] = v;
    req_we[p*SW +: SW] = we;
    req_addr[p*AW +: AW] = a;
    req_wrdata[p*DW +: DW] = d;
  endtask

  function automatic int grant_of(input logic [NP-1:0] r);
    int n, idx;
    n = 0; idx = -1;
    for (int p = 0; p < NP; p++) if (r[p]) begin n++; idx = p; end
    return (n > 1) ? 99 : idx;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    for (int p = 0; p < NP; p++) set_req(p, 1'b1, '0, AW'(16'h30 + p), '0);
    rsp_ready = '1;
    to_drive();
    for (int c = 0; c < 3; c++) begin
      to_check();
      n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL rst_req_ready got %b want 000", req_ready); end
      n_checks++; if (bram_en !== 1'b0 || bram_we !== 8'h00) begin n_fail++; $display("FAIL rst_bram got en=%b we=%h want 0/00", bram_en, bram_we); end
      n_checks++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL rst_rsp_valid got %b want 000", rsp_valid); end
      to_drive();
    end
    rst = 1'b0;
    req_valid = '0;
    to_check();
    n_checks++; if (rsp_valid !== 3'b000 || bram_en !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got rv=%b en=%b want 000/0", rsp_valid, bram_en); end
    to_drive();
  endtask

  task automatic test_read_latency();
    set_req(0, 1'b1, '0, 16'h10, '0);
    to_check();
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL t1_ready got %b want 001", req_ready); end
    n_checks++; if (bram_en !== 1'b1 || bram_we !== 8'h00 || bram_addr !== 16'h10) begin n_fail++; $display("FAIL t1_bram got en=%b we=%h addr=%h want 1/00/0010", bram_en, bram_we, bram_addr); end
    to_drive();
    req_valid[0] = 1'b0;
    to_check();
    n_checks++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL t1_rsp_early got %b want 000", rsp_valid); end
    to_drive();
    to_check();
    n_checks++; if (rsp_valid !== 3'b001) begin n_fail++; $display("FAIL t1_rsp_valid got %b want 001", rsp_valid); end
    n_checks++; if (rsp_data[0 +: DW] !== 64'hDEAD) begin n_fail++; $display("FAIL t1_rsp_data got %h want dead", rsp_data[0 +: DW]); end
    to_drive();
    to_check();
    n_checks++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL t1_rsp_once got %b want 000", rsp_valid); end
    to_drive();
  endtask

  task automatic test_round_robin();
    logic [NP-1:0] want_rv;
    int p;
    set_req(0, 1'b1, '0, 16'h20, '0);
    set_req(1, 1'b1, '0, 16'h21, '0);
    rsp_ready = '1;
    for (int c = 0; c < 10; c++) begin
      to_check();
      n_checks++; if (bram_en !== 1'b1 || grant_of(req_ready) !== ((c % 2 == 0) ? 1 : 0)) begin n_fail++; $display("FAIL t2_grant c=%0d got en=%b ready=%b want port %0d", c, bram_en, req_ready, (c % 2 == 0) ? 1 : 0); end
      if (c >= 2) begin
        p = (c % 2 == 0) ? 1 : 0;
        want_rv = '0; want_rv[p] = 1'b1;
        n_checks++; if (rsp_valid !== want_rv || rsp_data[p*DW +: DW] !== init_word(16'h20 + p)) begin n_fail++; $display("FAIL t2_rsp c=%0d got rv=%b data=%h want %b/%h", c, rsp_valid, rsp_data[p*DW +: DW], want_rv, init_word(16'h20 + p)); end
      end
      to_drive();
    end
    req_valid = '0;
    repeat (3) to_drive();
  endtask

  task automatic test_backpressure();
    rsp_ready = 3'b110;
    set_req(0, 1'b1, '0, 16'h40, '0);
    to_check();
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL t3_first_grant got %b want 001", req_ready); end
    to_drive();
    set_req(0, 1'b1, '0, 16'h41, '0);
    to_check();
    n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL t3_pend_block got %b want 000", req_ready); end
    to_drive();
    set_req(1, 1'b1, '0, 16'h50, '0);
    to_check();
    n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL t3_port1_grant got %b want 010", req_ready); end
    to_drive();
    req_valid[1] = 1'b0;
    for (int c = 3; c <= 4; c++) begin
      to_check();
      n_checks++; if (req_ready !== 3'b000 || rsp_valid[0] !== 1'b1 || rsp_data[0 +: DW] !== init_word(16'h40)) begin n_fail++; $display("FAIL t3_hold c=%0d got ready=%b rv0=%b data=%h want 000/1/%h", c, req_ready, rsp_valid[0], rsp_data[0 +: DW], init_word(16'h40)); end
      if (c == 4) begin
        n_checks++; if (rsp_valid[1] !== 1'b1 || rsp_data[DW +: DW] !== init_word(16'h50)) begin n_fail++; $display("FAIL t3_port1_rsp got rv1=%b data=%h want 1/%h", rsp_valid[1], rsp_data[DW +: DW], init_word(16'h50)); end
      end
      to_drive();
    end
    rsp_ready = 3'b111;
    to_check();
    n_checks++; if (req_ready !== 3'b001 || rsp_valid !== 3'b001) begin n_fail++; $display("FAIL t3_release got ready=%b rv=%b want 001/001", req_ready, rsp_valid); end
    to_drive();
    req_valid[0] = 1'b0;
    to_check();
    n_checks++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL t3_gap got %b want 000", rsp_valid); end
    to_drive();
    to_check();
    n_checks++; if (rsp_valid !== 3'b001 || rsp_data[0 +: DW] !== init_word(16'h41)) begin n_fail++; $display("FAIL t3_second_rsp got rv=%b data=%h want 001/%h", rsp_valid, rsp_data[0 +: DW], init_word(16'h41)); end
    to_drive();
    to_drive();
  endtask

  task automatic test_write();
    set_req(1, 1'b1, 8'h0F, 16'h5, 64'h1122334455667788);
    to_check();
    n_checks++; if (req_ready !== 3'b010 || bram_we !== 8'h0F || bram_addr !== 16'h5 || bram_wrdata !== 64'h1122334455667788) begin n_fail++; $display("FAIL t4_write got ready=%b we=%h addr=%h wd=%h", req_ready, bram_we, bram_addr, bram_wrdata); end
    to_drive();
    req_valid[1] = 1'b0;
    to_drive();
    to_check();
    n_checks++; if (rsp_valid !== 3'b010 || rsp_data[DW +: DW] !== 64'h0) begin n_fail++; $display("FAIL t4_wr_rsp got rv=%b data=%h want 010/0", rsp_valid, rsp_data[DW +: DW]); end
    to_drive();
    set_req(1, 1'b1, 8'h00, 16'h5, '0);
    to_check();
    n_checks++; if (req_ready !== 3'b010 || bram_we !== 8'h00) begin n_fail++; $display("FAIL t4_read_grant got ready=%b we=%h want 010/00", req_ready, bram_we); end
    to_drive();
    req_valid[1] = 1'b0;
    to_drive();
    to_check();
    n_checks++; if (rsp_valid !== 3'b010 || rsp_data[DW +: DW] !== 64'hC0DE000055667788) begin n_fail++; $display("FAIL t4_readback got rv=%b data=%h want 010/c0de000055667788", rsp_valid, rsp_data[DW +: DW]); end
    to_drive();
  endtask

  task automatic test_three_port();
    int seq [10];
    seq = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2};
    rst = 1'b1;
    to_drive();
    rst = 1'b0;
    for (int p = 0; p < NP; p++) set_req(p, 1'b1, '0, AW'(16'h60 + p), '0);
    rsp_ready = '1;
    for (int c = 0; c < 10; c++) begin
      to_check();
      n_checks++; if (grant_of(req_ready) !== seq[c]) begin n_fail++; $display("FAIL t5_order c=%0d got ready=%b want port %0d", c, req_ready, seq[c]); end
      to_drive();
      if (c == 4) req_valid[1] = 1'b0;
    end
    req_valid = '0;
    repeat (3) to_drive();
  endtask

  task automatic test_reset_inflight();
    set_req(0, 1'b1, '0, 16'h70, '0);
    to_check();
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL t6_grant got %b want 001", req_ready); end
    to_drive();
    rst = 1'b1;
    set_req(1, 1'b1, '0, 16'h71, '0);
    to_check();
    n_checks++; if (bram_en !== 1'b0 || req_ready !== 3'b000 || rsp_valid !== 3'b000) begin n_fail++; $display("FAIL t6_in_rst got en=%b ready=%b rv=%b want 0/000/000", bram_en, req_ready, rsp_valid); end
    to_drive();
    rst = 1'b0;
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      to_check();
      n_checks++; if (rsp_valid !== 3'b000) begin n_fail++; $display("FAIL t6_no_rsp c=%0d got %b want 000", c, rsp_valid); end
      to_drive();
    end
    req_valid = 3'b011;
    to_check();
    n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL t6_first_after_rst got %b want 001", req_ready); end
    to_drive();
    req_valid = '0;
    repeat (3) to_drive();
  endtask

  task automatic test_random();
    logic [NP-1:0] rdy_seen;
    for (int c = 0; c < 400; c++) begin
      to_check();
      n_checks++; if (req_ready !== exp_ready || bram_en !== exp_en) begin n_fail++; $display("FAIL rnd_grant c=%0d got ready=%b en=%b want %b/%b", c, req_ready, bram_en, exp_ready, exp_en); end
      if (exp_en) begin
        n_checks++; if (bram_we !== exp_we || bram_addr !== exp_addr || bram_wrdata !== exp_wd) begin n_fail++; $display("FAIL rnd_payload c=%0d got we=%h a=%h wd=%h want %h/%h/%h", c, bram_we, bram_addr, bram_wrdata, exp_we, exp_addr, exp_wd); end
      end else begin
        n_checks++; if (bram_we !== 8'h00) begin n_fail++; $display("FAIL rnd_idle_we c=%0d got %h want 00", c, bram_we); end
      end
      n_checks++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rnd_rsp_valid c=%0d got %b want %b", c, rsp_valid, exp_rv); end
      for (int p = 0; p < NP; p++)
        if (exp_rv[p]) begin
          n_checks++; if (rsp_data[p*DW +: DW] !== exp_rd[p]) begin n_fail++; $display("FAIL rnd_rsp_data c=%0d p=%0d got %h want %h", c, p, rsp_data[p*DW +: DW], exp_rd[p]); end
        end
      rdy_seen = req_ready;
      to_drive();
      rst = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < NP; p++) begin
        if (!req_valid[p] || rdy_seen[p])
          set_req(p, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0) ? SW'($urandom) : '0,
                  AW'($urandom_range(0, 15)), {$urandom, $urandom});
        rsp_ready[p] = ($urandom_range(0, 3) != 0);
      end
    end
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = '1;
    repeat (3) to_drive();
  endtask

  initial begin
    for (int a = 0; a < 256; a++) begin
      mem[a]    = init_word(a);
      shadow[a] = init_word(a);
    end
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wrdata = '0; rsp_ready = '0;
    test_reset();
    test_read_latency();
    test_round_robin();
    test_backpressure();
    test_write();
    test_three_port();
    test_reset_inflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
